first_nios2_system_pio_sequencer: RTL and testbench
===================================================

Name: first_nios2_system_pio_sequencer

Overview:
- Avalon-MM sequencer that drives an 8-bit output PIO slave: plays a programmable pattern table to the PIO data register, with a fixed spacing between writes.
- Nios II configures and starts it through its own zero-wait CSR slave (s_*); it issues single-cycle writes to the PIO through a master port (m_*).
- Sits between the CPU interconnect and the PIO, so the CPU does not busy-loop to generate LED/GPIO patterns.

Parameters:
- DATA_W, 8, PIO data width, in bits.
- DEPTH, 16, number of pattern entries; must be a power of 2, at most 16.
- PTR_W, 4, log2(DEPTH).
- DWELL_W, 16, width of the dwell counter.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- s_address  in  5  CSR word address
- s_chipselect  in  1  CSR select
- s_write_n  in  1  CSR write strobe, active low
- s_writedata  in  32  CSR write data
- s_readdata  out  32  CSR read data, combinational, zero wait
- m_address  out  2  PIO address, constant 0
- m_chipselect  out  1  PIO select
- m_write_n  out  1  PIO write strobe, active low
- m_writedata  out  32  {zero-extended, pattern entry}

Behaviour:
- Reset is asynchronous, active-low, on reset_n; clock is clk.
- Reset values:
  - all pattern entries, DWELL, LENGTH, LOOP and DONE = 0; FSM = IDLE
  - m_chipselect = 0, m_write_n = 1, m_address = 0, m_writedata = 0
- CSR map (word addresses); a write occurs when s_chipselect = 1 and s_write_n = 0.
  - 0 CTRL:
    - write: bit0 = START, bit1 = LOOP, bit2 = STOP.
    - read: {29'b0, IRQ_ENA, LOOP, busy}. IRQ_ENA is bit2 and reads 0 unless the optional feature is compiled in.
  - 1 STATUS:
    - read: {20'b0, index[PTR_W-1:0] at [11:8], 6'b0, DONE, busy}.
    - write 1 to bit1 clears DONE.
  - 2 DWELL: write/read, [DWELL_W-1:0].
  - 3 LENGTH: write/read, [PTR_W:0].
    - Values above DEPTH are clamped to DEPTH on write.
    - Writes while busy are ignored.
  - 16..16+DEPTH-1 PATTERN[i]: write/read, [DATA_W-1:0].
  - Unmapped addresses read 0; writes to them are dropped.
- FSM states:
  - IDLE:
    - START with LENGTH = 0: set DONE, stay in IDLE, no PIO write.
    - START otherwise: index = 0, clear DONE, go to WRITE.
  - WRITE:
    - One cycle with m_chipselect = 1, m_write_n = 0, m_writedata = PATTERN[index].
    - The PIO has no waitrequest, so the write completes in that cycle.
    - DWELL = 0: go straight to the next step (rules below).
    - DWELL > 0: load cnt = DWELL - 1, go to DWELL.
  - DWELL:
    - cnt != 0: decrement cnt.
    - cnt == 0: take the next step.
  - Next step:
    - index < LENGTH-1: index + 1, go to WRITE.
    - Last entry with LOOP = 1: index = 0, go to WRITE.
    - Last entry with LOOP = 0: set DONE, go to IDLE.
- Write-strobe spacing is exactly DWELL + 1 cycles. DWELL = 0 gives back-to-back strobes.
- m_* outputs are registered, decoded from the next state: the first strobe appears in the cycle after the START write.
- busy = (state != IDLE).
- STOP while busy:
  - FSM goes to IDLE next cycle, with no further strobes.
  - A strobe already in flight in the STOP cycle completes.
  - DONE is not set.
- START while busy restarts the sequence: index = 0, WRITE next cycle.
- START and STOP in the same write: STOP wins.
- PATTERN/DWELL writes while busy are accepted:
  - A PATTERN write takes effect the next time that entry is emitted.
  - A DWELL write takes effect at the next dwell load.
- The LOOP bit is latched on every CTRL write and may change mid-run; it is evaluated at the last entry.
- Reset mid-run: immediate return to IDLE; m_write_n = 1 asynchronously.

Optional Feature:
- Macro: FIRST_NIOS2_SYSTEM_PIO_SEQUENCER_IRQ_EN
- Defined:
  - Adds output irq (1 bit), registered, irq = DONE & IRQ_ENA.
  - IRQ_ENA is CTRL bit3 on write, bit2 on read; reset value 0.
- Undefined:
  - No irq port.
  - IRQ_ENA is not stored and reads 0.

Decomposition:
- Package first_nios2_system_pio_sequencer_pkg:
  - FSM state enum {IDLE, WRITE, DWELL}
  - CSR address constants (CTRL = 0, STATUS = 1, DWELL = 2, LENGTH = 3, PATTERN_BASE = 16)
  - CTRL/STATUS bit-position constants
- One sub-module, first_nios2_system_pio_sequencer_dwell_cnt:
  - load/decrement counter with a zero flag, DWELL_W wide.

Test Plan:
- Basic run:
  - Stimulus: PATTERN[0..2] = 0x01, 0x02, 0x04; LENGTH = 3; DWELL = 3; CTRL = START.
  - Response: 3 strobes with writedata 0x01, 0x02, 0x04, 4 cycles apart; then DONE = 1, busy = 0.
- Back-to-back:
  - Stimulus: DWELL = 0, LENGTH = 4.
  - Response: 4 consecutive strobe cycles.
- Loop:
  - Stimulus: LOOP = 1, LENGTH = 2, DWELL = 1.
  - Response: strobes alternate 0x01, 0x02 every 2 cycles indefinitely; DONE stays 0.
- Stop:
  - Stimulus: STOP written during the second dwell.
  - Response: no further strobes; busy = 0 next cycle; DONE = 0.
- Edge cases:
  - START with LENGTH = 0: DONE = 1, zero strobes.
  - START while busy: next strobe carries PATTERN[0].
  - LENGTH = 20 written: reads back 16.
- Reset mid-run: assert reset_n = 0 during WRITE.
  - m_write_n = 1 immediately.
  - All CSRs read 0 after release.

Source files
------------

// File: rtl/first_nios2_system_pio_sequencer_pkg.sv
// Shared types and CSR constants for the PIO pattern sequencer.
package first_nios2_system_pio_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWrite = 2'd1,
    StDwell = 2'd2
  } state_e;

  localparam logic [4:0] AddrCtrl        = 5'd0;
  localparam logic [4:0] AddrStatus      = 5'd1;
  localparam logic [4:0] AddrDwell       = 5'd2;
  localparam logic [4:0] AddrLength      = 5'd3;
  localparam logic [4:0] AddrPatternBase = 5'd16;

  localparam int unsigned CtrlStartBit    = 0;
  localparam int unsigned CtrlLoopBit     = 1;
  localparam int unsigned CtrlStopBit     = 2;
  localparam int unsigned CtrlIrqEnaWrBit = 3;
  localparam int unsigned CtrlBusyRdBit   = 0;
  localparam int unsigned CtrlLoopRdBit   = 1;
  localparam int unsigned CtrlIrqEnaRdBit = 2;

  localparam int unsigned StatusBusyBit    = 0;
  localparam int unsigned StatusDoneBit    = 1;
  localparam int unsigned StatusDoneClrBit = 1;
  localparam int unsigned StatusIndexLsb   = 8;

endpackage

// File: rtl/first_nios2_system_pio_sequencer_dwell_cnt.sv
// Load/decrement dwell counter with a zero flag; load has priority over decrement.
module first_nios2_system_pio_sequencer_dwell_cnt #(
  parameter int unsigned DWELL_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  input  logic               dec,
  output logic               zero
);

  logic [DWELL_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec) begin
      cnt_d = cnt_q - DWELL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/first_nios2_system_pio_sequencer.sv
// Avalon-MM sequencer playing a pattern table into an 8-bit PIO data register.
// Optional irq output enabled by defining FIRST_NIOS2_SYSTEM_PIO_SEQUENCER_IRQ_EN.
module first_nios2_system_pio_sequencer
  import first_nios2_system_pio_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned PTR_W   = 4,
  parameter int unsigned DWELL_W = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  s_address,
  input  logic        s_chipselect,
  input  logic        s_write_n,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
`ifdef FIRST_NIOS2_SYSTEM_PIO_SEQUENCER_IRQ_EN
  output logic        irq,
`endif
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata
);

  localparam logic [PTR_W:0] DepthLen = (PTR_W+1)'(DEPTH);

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    index_q, index_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   pattern_q [DEPTH];
  logic [DWELL_W-1:0]  dwell_q;
  logic [PTR_W:0]      length_q;
  logic                loop_q;
  logic                m_cs_q;
  logic [DATA_W-1:0]   m_wd_q;
  logic                irq_ena;

  logic                csr_we, ctrl_we, status_we, dwell_we, length_we, pat_we;
  logic                start_cmd, stop_cmd, done_clr;
  logic                pat_sel;
  logic [4:0]          pat_off;
  logic [PTR_W-1:0]    pat_idx;
  logic [PTR_W:0]      length_wr;
  logic                busy, last_entry, next_step;
  logic                cnt_load, cnt_dec, cnt_zero;

  // CSR decode
  assign csr_we    = s_chipselect & ~s_write_n;
  assign pat_off   = s_address - AddrPatternBase;
  assign pat_sel   = (s_address >= AddrPatternBase) && ({27'd0, pat_off} < DEPTH);
  assign pat_idx   = pat_off[PTR_W-1:0];
  assign ctrl_we   = csr_we && (s_address == AddrCtrl);
  assign status_we = csr_we && (s_address == AddrStatus);
  assign dwell_we  = csr_we && (s_address == AddrDwell);
  assign length_we = csr_we && (s_address == AddrLength);
  assign pat_we    = csr_we && pat_sel;
  assign start_cmd = ctrl_we & s_writedata[CtrlStartBit];
  assign stop_cmd  = ctrl_we & s_writedata[CtrlStopBit];
  assign done_clr  = status_we & s_writedata[StatusDoneClrBit];
  assign length_wr = (s_writedata > DEPTH) ? DepthLen : s_writedata[PTR_W:0];

  assign busy       = (state_q != StIdle);
  assign last_entry = ({1'b0, index_q} == (length_q - (PTR_W+1)'(1)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pattern_q[i] <= '0;
      end
      dwell_q  <= '0;
      length_q <= '0;
      loop_q   <= 1'b0;
    end else begin
      if (ctrl_we) loop_q <= s_writedata[CtrlLoopBit];
      if (dwell_we) dwell_q <= s_writedata[DWELL_W-1:0];
      if (length_we && !busy) length_q <= length_wr;
      if (pat_we) pattern_q[pat_idx] <= s_writedata[DATA_W-1:0];
    end
  end

  first_nios2_system_pio_sequencer_dwell_cnt #(
    .DWELL_W (DWELL_W)
  ) u_dwell_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (dwell_q - DWELL_W'(1)),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    done_d    = done_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    next_step = 1'b0;

    unique case (state_q)
      StIdle: state_d = StIdle;
      StWrite: begin
        if (dwell_q == '0) begin
          next_step = 1'b1;
        end else begin
          cnt_load = 1'b1;
          state_d  = StDwell;
        end
      end
      StDwell: begin
        if (cnt_zero) next_step = 1'b1;
        else          cnt_dec   = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (next_step) begin
      if (!last_entry) begin
        index_d = index_q + PTR_W'(1);
        state_d = StWrite;
      end else if (loop_q) begin
        index_d = '0;
        state_d = StWrite;
      end else begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
    end

    // STOP overrides both START and a completion in the same cycle; DONE stays as it was.
    if (stop_cmd) begin
      state_d = StIdle;
      index_d = index_q;
      done_d  = done_q;
    end else if (start_cmd) begin
      if (!busy && (length_q == '0)) begin
        done_d = 1'b1;
      end else begin
        index_d = '0;
        done_d  = 1'b0;
        state_d = StWrite;
      end
    end

    if (done_clr) done_d = 1'b0;
  end

  // Master outputs are registered from the next state so the strobe lines up with StWrite.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      index_q <= '0;
      done_q  <= 1'b0;
      m_cs_q  <= 1'b0;
      m_wd_q  <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      done_q  <= done_d;
      m_cs_q  <= (state_d == StWrite);
      if (state_d == StWrite) m_wd_q <= pattern_q[index_d];
    end
  end

  assign m_address    = 2'd0;
  assign m_chipselect = m_cs_q;
  assign m_write_n    = ~m_cs_q;
  assign m_writedata  = {{(32-DATA_W){1'b0}}, m_wd_q};

`ifdef FIRST_NIOS2_SYSTEM_PIO_SEQUENCER_IRQ_EN
  logic irq_ena_q, irq_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_ena_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      if (ctrl_we) irq_ena_q <= s_writedata[CtrlIrqEnaWrBit];
      irq_q <= done_q & irq_ena_q;
    end
  end

  assign irq     = irq_q;
  assign irq_ena = irq_ena_q;
`else
  assign irq_ena = 1'b0;
`endif

  always_comb begin
    s_readdata = '0;
    if (pat_sel) begin
      s_readdata[DATA_W-1:0] = pattern_q[pat_idx];
    end else begin
      case (s_address)
        AddrCtrl: begin
          s_readdata[CtrlBusyRdBit]   = busy;
          s_readdata[CtrlLoopRdBit]   = loop_q;
          s_readdata[CtrlIrqEnaRdBit] = irq_ena;
        end
        AddrStatus: begin
          s_readdata[StatusBusyBit]                 = busy;
          s_readdata[StatusDoneBit]                 = done_q;
          s_readdata[StatusIndexLsb +: PTR_W]       = index_q;
        end
        AddrDwell:  s_readdata[DWELL_W-1:0] = dwell_q;
        AddrLength: s_readdata[PTR_W:0]     = length_q;
        default:    s_readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_first_nios2_system_pio_sequencer.sv
// Directed bench with a cycle-schedule model of the PIO strobe sequence.
module tb_first_nios2_system_pio_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  s_address = '0;
  logic        s_chipselect = 1'b0;
  logic        s_write_n = 1'b1;
  logic [31:0] s_writedata = '0;
  logic [31:0] s_readdata;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
`ifdef FIRST_NIOS2_SYSTEM_PIO_SEQUENCER_IRQ_EN
  logic        irq;
`endif

  first_nios2_system_pio_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_address    (s_address),
    .s_chipselect (s_chipselect),
    .s_write_n    (s_write_n),
    .s_writedata  (s_writedata),
    .s_readdata   (s_readdata),
`ifdef FIRST_NIOS2_SYSTEM_PIO_SEQUENCER_IRQ_EN
    .irq          (irq),
`endif
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write_n    (m_write_n),
    .m_writedata  (m_writedata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_cyc = 0;
  bit chk_en = 1'b0;

  typedef struct {
    int         c;
    logic [7:0] d;
  } obs_t;
  obs_t obs[$];

  // Model: strobe schedule in absolute cycle numbers
  bit         m_busy, m_done, m_exp_cs, m_loop;
  logic [7:0] m_exp_data;
  logic [7:0] m_pat [16];
  int         m_k, m_next, m_dwell, m_len;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_exp_cs = 0; m_loop = 0; m_exp_data = '0;
    m_k = 0; m_next = 0; m_dwell = 0; m_len = 0;
    for (int i = 0; i < 16; i++) m_pat[i] = '0;
  endtask

  task automatic model_emit();
    m_exp_cs   = 1;
    m_exp_data = m_pat[m_k];
    m_next     = cyc + m_dwell + 1;
  endtask

  task automatic model_step();
    bit we, ctrl, busy_prev;
    we = s_chipselect && !s_write_n;
    ctrl = we && (s_address == 5'd0);
    busy_prev = m_busy;
    m_exp_cs = 0;
    if (ctrl && s_writedata[2]) begin
      m_busy = 0;
    end else if (ctrl && s_writedata[0]) begin
      if (!busy_prev && m_len == 0) m_done = 1;
      else begin
        m_busy = 1; m_done = 0; m_k = 0;
        model_emit();
      end
    end else if (m_busy && cyc == m_next) begin
      if (m_k == m_len - 1 && !m_loop) begin
        m_busy = 0; m_done = 1;
      end else begin
        m_k = (m_k == m_len - 1) ? 0 : m_k + 1;
        model_emit();
      end
    end
    if (ctrl) m_loop = s_writedata[1];
    if (we && s_address == 5'd1 && s_writedata[1]) m_done = 0;
    if (we && s_address == 5'd2) m_dwell = int'(s_writedata[15:0]);
    if (we && s_address == 5'd3 && !busy_prev)
      m_len = (s_writedata > 32'd16) ? 16 : int'(s_writedata[4:0]);
    if (we && s_address >= 5'd16) m_pat[s_address - 5'd16] = s_writedata[7:0];
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else begin
        cyc++;
        model_step();
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("m_chipselect", {31'd0, m_chipselect}, {31'd0, m_exp_cs});
        check("m_write_n", {31'd0, m_write_n}, {31'd0, !m_exp_cs});
        check("m_address", {30'd0, m_address}, 32'd0);
        if (m_exp_cs) check("m_writedata", m_writedata, {24'd0, m_exp_data});
      end
      if (m_chipselect) obs.push_back('{cyc, m_writedata[7:0]});
    end
  end

  task automatic csr_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    s_address = a; s_writedata = d; s_chipselect = 1'b1; s_write_n = 1'b0;
    wr_cyc = cyc;
    @(negedge clk);
    s_chipselect = 1'b0; s_write_n = 1'b1;
  endtask

  task automatic csr_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    s_address = a; s_chipselect = 1'b1; s_write_n = 1'b1;
    #1 d = s_readdata;
    s_chipselect = 1'b0;
  endtask

  task automatic check_status(input string name);
    logic [31:0] d;
    logic [3:0]  k;
    k = m_k[3:0];
    csr_read(5'd1, d);
    check(name, d, {20'd0, k, 6'd0, m_done, m_busy});
  endtask

  task automatic check_reg(input string name, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] d;
    csr_read(a, d);
    check(name, d, exp);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [31:0] rd;

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    check("reset_write_n", {31'd0, m_write_n}, 32'd1);
    check("reset_writedata", m_writedata, 32'd0);
    check_reg("reset_ctrl", 5'd0, 32'd0);
    check_reg("reset_status", 5'd1, 32'd0);
    check_reg("reset_pattern0", 5'd16, 32'd0);

    // Basic run
    csr_write(5'd16, 32'h01);
    csr_write(5'd17, 32'h02);
    csr_write(5'd18, 32'h04);
    csr_write(5'd19, 32'h08);
    csr_write(5'd3, 32'd3);
    csr_write(5'd2, 32'd3);
    check_reg("pattern2_rd", 5'd18, 32'h04);
    check_reg("length_rd", 5'd3, 32'd3);
    check_reg("dwell_rd", 5'd2, 32'd3);
    obs.delete();
    csr_write(5'd0, 32'h1);
    wait_cycles(16);
    check("basic_count", obs.size(), 3);
    if (obs.size() == 3) begin
      check("basic_first_cycle", obs[0].c, wr_cyc + 1);
      check("basic_d0", {24'd0, obs[0].d}, 32'h01);
      check("basic_d1", {24'd0, obs[1].d}, 32'h02);
      check("basic_d2", {24'd0, obs[2].d}, 32'h04);
      check("basic_gap1", obs[1].c - obs[0].c, 4);
      check("basic_gap2", obs[2].c - obs[1].c, 4);
    end
    csr_read(5'd1, rd);
    check("basic_done_lit", rd & 32'h3, 32'h2);
    check_status("basic_status");

    // Back-to-back
    csr_write(5'd2, 32'd0);
    csr_write(5'd3, 32'd4);
    obs.delete();
    csr_write(5'd0, 32'h1);
    wait_cycles(8);
    check("b2b_count", obs.size(), 4);
    if (obs.size() == 4) begin
      check("b2b_consecutive", obs[3].c - obs[0].c, 3);
      check("b2b_d3", {24'd0, obs[3].d}, 32'h08);
    end
    check_status("b2b_status");

    // Loop
    csr_write(5'd3, 32'd2);
    csr_write(5'd2, 32'd1);
    obs.delete();
    csr_write(5'd0, 32'h3);
    wait_cycles(11);
    check("loop_count_ge5", {31'd0, obs.size() >= 5}, 32'd1);
    if (obs.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        check("loop_data", {24'd0, obs[i].d}, (i % 2 == 0) ? 32'h01 : 32'h02);
        if (i > 0) check("loop_gap", obs[i].c - obs[i-1].c, 2);
      end
    end
    csr_read(5'd1, rd);
    check("loop_busy_lit", rd & 32'h3, 32'h1);
    csr_write(5'd0, 32'h4);
    check_status("loop_stop_status");

    // Stop during the second dwell
    csr_write(5'd3, 32'd3);
    csr_write(5'd2, 32'd3);
    obs.delete();
    csr_write(5'd0, 32'h1);
    wait_cycles(4);
    csr_write(5'd0, 32'h4);
    csr_read(5'd1, rd);
    check("stop_idle_lit", rd & 32'h3, 32'h0);
    wait_cycles(10);
    check("stop_count", obs.size(), 2);
    check_status("stop_status");

    // START with LENGTH = 0
    csr_write(5'd3, 32'd0);
    obs.delete();
    csr_write(5'd0, 32'h1);
    wait_cycles(5);
    check("len0_count", obs.size(), 0);
    csr_read(5'd1, rd);
    check("len0_done_lit", rd & 32'h3, 32'h2);
    csr_write(5'd1, 32'h2);
    csr_read(5'd1, rd);
    check("done_clear_lit", rd & 32'h3, 32'h0);

    // START while busy restarts from entry 0
    csr_write(5'd3, 32'd3);
    obs.delete();
    csr_write(5'd0, 32'h1);
    wait_cycles(4);
    csr_write(5'd0, 32'h1);
    wait_cycles(2);
    check("restart_count_ge3", {31'd0, obs.size() >= 3}, 32'd1);
    if (obs.size() >= 3) begin
      check("restart_data", {24'd0, obs[2].d}, 32'h01);
      check("restart_gap", obs[2].c - obs[1].c, 2);
    end
    // LENGTH writes ignored while busy
    csr_write(5'd3, 32'd1);
    check_reg("length_busy_rd", 5'd3, 32'd3);
    csr_write(5'd0, 32'h4);
    wait_cycles(2);

    // LENGTH clamp and unmapped address
    csr_write(5'd3, 32'd20);
    check_reg("length_clamp", 5'd3, 32'd16);
    check_reg("unmapped_rd", 5'd5, 32'd0);
    csr_write(5'd3, 32'd3);

    // Reset during WRITE
    csr_write(5'd0, 32'h1);
    check("pre_reset_strobe", {31'd0, m_chipselect}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("reset_async_write_n", {31'd0, m_write_n}, 32'd1);
    check("reset_async_cs", {31'd0, m_chipselect}, 32'd0);
    wait_cycles(2);
    reset_n = 1'b1;
    check_reg("post_reset_ctrl", 5'd0, 32'd0);
    check_reg("post_reset_status", 5'd1, 32'd0);
    check_reg("post_reset_dwell", 5'd2, 32'd0);
    check_reg("post_reset_length", 5'd3, 32'd0);
    check_reg("post_reset_pat0", 5'd16, 32'd0);
    check_reg("post_reset_pat2", 5'd18, 32'd0);
    wait_cycles(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
